// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage (pc_fetch).
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_WAIT,
        S_DISCARD,
        S_ADEL
    } fetch_state_t;

    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// IF stage: owns the PC and fetches over a single-outstanding req/ack bus.
// Optional misaligned-fetch trap enabled by defining PC_FETCH_ADEL_CHECK_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    output logic        stallreq,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i
);

    // Bus handshake: a transfer completes in the cycle where ibus_req_o and
    // ibus_ack_i are both high; ibus_rdata_i is valid in that same cycle, the
    // address is held until then, and an ack seen while req is low is ignored.

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  redirect_pc;
    logic         redirect_pend;
    logic [31:0]  inst_buf;
    logic [31:0]  disc_addr;

    logic         fetching;
    logic         branch_live;
    logic         advance;
    logic [31:0]  next_pc;
    fetch_state_t adv_state;
    logic         unused_stall;

    assign unused_stall = ^{stall[5:3], stall[1]};

    assign fetching    = (state == S_IDLE) || (state == S_BUSY);
    assign branch_live = branch_flag_i && (stall[2] == NO_STOP);
    assign advance     = !flush && (stall[0] == NO_STOP) &&
                         ((fetching && ibus_ack_i) || (state == S_WAIT));
    assign next_pc     = branch_live   ? branch_addr_i :
                         redirect_pend ? redirect_pc   : pc + 32'd4;

`ifdef PC_FETCH_ADEL_CHECK_EN
    // A misaligned target is trapped locally instead of going to the bus.
    assign adv_state = misaligned(next_pc[1:0]) ? S_ADEL : S_BUSY;
`else
    assign adv_state = S_BUSY;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            redirect_pc   <= ZERO_WORD;
            redirect_pend <= 1'b0;
            inst_buf      <= ZERO_WORD;
            disc_addr     <= ZERO_WORD;
        end else if (flush) begin
            pc            <= new_pc;
            redirect_pend <= 1'b0;
            case (state)
                S_IDLE, S_BUSY: begin
                    if (ibus_ack_i) begin
                        state <= S_IDLE;
                    end else begin
                        state     <= S_DISCARD;
                        disc_addr <= pc;
                    end
                end
                S_DISCARD: if (ibus_ack_i) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end else begin
            if (advance) begin
                pc            <= next_pc;
                redirect_pend <= 1'b0;
            end else if (branch_live) begin
                redirect_pend <= 1'b1;
                redirect_pc   <= branch_addr_i;
            end
            case (state)
                S_IDLE, S_BUSY: begin
                    if (ibus_ack_i) begin
                        if (stall[0] == STOP) begin
                            inst_buf <= ibus_rdata_i;
                            state    <= S_WAIT;
                        end else begin
                            state <= adv_state;
                        end
                    end else begin
                        state <= S_BUSY;
                    end
                end
                S_WAIT:    if (stall[0] == NO_STOP) state <= adv_state;
                S_DISCARD: if (ibus_ack_i) state <= S_IDLE;
                default:   state <= state;
            endcase
        end
    end

    // Outputs are decoded from state; they read as zero while reset is held.
    always_comb begin
        ibus_req_o  = 1'b0;
        ibus_addr_o = ZERO_WORD;
        stallreq    = 1'b0;
        if_pc       = ZERO_WORD;
        if_inst     = ZERO_WORD;
        if_adel     = 1'b0;
        if (!rst) begin
            if_pc = flush ? ZERO_WORD : pc;
            case (state)
                S_IDLE, S_BUSY: begin
                    ibus_req_o  = 1'b1;
                    ibus_addr_o = pc;
                    stallreq    = !ibus_ack_i;
                    if_inst     = ibus_ack_i ? ibus_rdata_i : ZERO_WORD;
                end
                S_WAIT: begin
                    if_inst = inst_buf;
                end
                S_DISCARD: begin
                    ibus_req_o  = 1'b1;
                    ibus_addr_o = disc_addr;
                    stallreq    = 1'b1;
                end
                default: begin
`ifdef PC_FETCH_ADEL_CHECK_EN
                    if_adel = 1'b1;
`endif
                end
            endcase
            if (flush) if_inst = ZERO_WORD;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios then random ack/stall/branch
// traffic checked against an instruction-stream reference model.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        stallreq;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;

    int checks = 0;
    int passed = 0;

    // Reference model: the instruction stream the core should see.
    logic [31:0] exp_addr;
    logic        holding;
    logic [31:0] held_word;
    logic        pend;
    logic [31:0] pend_tgt;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .stallreq      (stallreq),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_adel       (if_adel),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_ack_i    (ibus_ack_i),
        .ibus_rdata_i  (ibus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign ibus_rdata_i = mem_word(ibus_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_redirect(input logic [31:0] addr);
        exp_addr = addr;
        holding  = 1'b0;
        pend     = 1'b0;
    endtask

    // One clock of normal traffic: drive, check against the model, update it.
    task automatic step(input bit a, input bit s0, input bit br, input logic [31:0] tgt);
        @(negedge clk);
        ibus_ack_i    = a;
        stall         = {5'b0, s0};
        branch_flag_i = br;
        branch_addr_i = tgt;
        flush         = 1'b0;
        #1;
        if (holding) begin
            check("held_req", 32'(ibus_req_o), 32'd0);
            check("held_inst", if_inst, held_word);
            check("held_pc", if_pc, exp_addr);
            check("held_stallreq", 32'(stallreq), 32'd0);
        end else begin
            check("fetch_req", 32'(ibus_req_o), 32'd1);
            check("fetch_addr", ibus_addr_o, exp_addr);
            check("fetch_pc", if_pc, exp_addr);
            check("fetch_inst", if_inst, a ? mem_word(exp_addr) : 32'd0);
            check("fetch_stallreq", 32'(stallreq), a ? 32'd0 : 32'd1);
        end
        check("adel_low", 32'(if_adel), 32'd0);
        if (br) begin
            pend     = 1'b1;
            pend_tgt = tgt;
        end
        if (holding ? !s0 : (a && !s0)) begin
            exp_addr = pend ? pend_tgt : exp_addr + 32'd4;
            pend     = 1'b0;
            holding  = 1'b0;
        end else if (!holding && a) begin
            holding   = 1'b1;
            held_word = mem_word(exp_addr);
        end
    endtask

    task automatic flush_cycle(input bit a, input logic [31:0] target);
        @(negedge clk);
        ibus_ack_i    = a;
        stall         = 6'b0;
        branch_flag_i = 1'b0;
        flush         = 1'b1;
        new_pc        = target;
        #1;
        check("flush_inst", if_inst, 32'd0);
        check("flush_pc", if_pc, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 6'b0; flush = 1'b0; new_pc = 32'd0;
        branch_flag_i = 1'b0; branch_addr_i = 32'd0; ibus_ack_i = 1'b1;
        model_redirect(32'h0000_0000);
        held_word = 32'd0; pend_tgt = 32'd0;

        // Reset state, with a stray ack present.
        #1;
        check("rst_req", 32'(ibus_req_o), 32'd0);
        check("rst_addr", ibus_addr_o, 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_inst", if_inst, 32'd0);
        @(negedge clk);
        ibus_ack_i = 1'b0;
        rst        = 1'b0;

        // Zero-wait slave: back-to-back fetches of 0,4,8,C.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Ack at 0x10 while PC is stalled for two cycles, then 0x14.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Three wait states on 0x14.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        // Branch to 0x100 while 0x18 is still waiting.
        step(0, 0, 1, 32'h0000_0100);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Flush to 0x180 mid-fetch of 0x104: old request drains, data dropped.
        step(0, 0, 0, 0);
        flush_cycle(0, 32'h0000_0180);
        @(negedge clk);
        flush = 1'b0; ibus_ack_i = 1'b0;
        #1;
        check("disc_req", 32'(ibus_req_o), 32'd1);
        check("disc_addr", ibus_addr_o, 32'h0000_0104);
        check("disc_stallreq", 32'(stallreq), 32'd1);
        check("disc_pc", if_pc, 32'h0000_0180);
        @(negedge clk);
        ibus_ack_i = 1'b1;
        #1;
        check("disc_drop_inst", if_inst, 32'd0);
        check("disc_ack_addr", ibus_addr_o, 32'h0000_0104);
        model_redirect(32'h0000_0180);
        step(1, 0, 0, 0);

        // Flush coincident with an ack, to the top of the address space; PC wraps.
        flush_cycle(1, 32'hFFFF_FFFC);
        model_redirect(32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Branch to a misaligned target.
        step(1, 0, 1, 32'h0000_0102);
`ifdef PC_FETCH_ADEL_CHECK_EN
        @(negedge clk);
        ibus_ack_i = 1'b0; branch_flag_i = 1'b0;
        #1;
        check("adel_req", 32'(ibus_req_o), 32'd0);
        check("adel_flag", 32'(if_adel), 32'd1);
        check("adel_pc", if_pc, 32'h0000_0102);
        check("adel_inst", if_inst, 32'd0);
        check("adel_stallreq", 32'(stallreq), 32'd0);
        flush_cycle(0, 32'h0000_0300);
`else
        step(1, 0, 0, 0);
        flush_cycle(1, 32'h0000_0300);
`endif
        model_redirect(32'h0000_0300);

        // Flush while an instruction is buffered under stall.
        step(1, 1, 0, 0);
        flush_cycle(0, 32'h0000_0400);
        model_redirect(32'h0000_0400);

        // Random ack timing, PC stalls and branches (spurious acks included).
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC);
        end

        // Reset in the middle of a pending fetch drops req at once.
        step(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(ibus_req_o), 32'd0);
        check("midrst_stallreq", 32'(stallreq), 32'd0);
        check("midrst_pc", if_pc, 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
